// File: rtl/radiant_trigger_governor.sv
// radiant_trigger_governor
//   Merges NUM_SRC single-cycle trigger flags into one accepted trigger per
//   event. It applies a per-source enable and prescale, then holds a lock
//   until the LAB4D readout sequencer reports completion. It also emits a
//   source mask, an event number and an external trigger one-shot.
//
//   Optional feature macro: RADIANT_TRIG_DEADCNT_EN
//     When defined, dead_cycles_o counts the armed cycles spent outside IDLE.
//     This count saturates. When undefined, dead_cycles_o is tied to 0.
//
//   Interface semantics: every flag input (src_i, readout_done_i,
//   soft_flow_clr_i) is a single-cycle pulse sampled on sys_clk_i. There is
//   no back-pressure toward the sources. A hit that arrives while the lock is
//   held is reported on dead_trig_o and is otherwise dropped. trig_o,
//   trig_done_o and dead_trig_o are single-cycle registered pulses.
//   trig_mask_o and evnum_o are stable from the trig_o cycle until the next
//   trig_o.
//
//   state_o exposes the FSM state for observation:
//     0 DISABLED, 1 IDLE, 2 TRIG, 3 BUSY, 4 HOLD, 5 HOLDOFF
module radiant_trigger_governor #(
  parameter int NUM_SRC        = 4,
  parameter int PRESCALE_WIDTH = 8,
  parameter int HOLDOFF_WIDTH  = 8,
  parameter int EVCNT_WIDTH    = 32,
  parameter int EXT_LEN_WIDTH  = 5,
  parameter int EXT_LOGIC_TRUE = 0
) (
  input  logic                              sys_clk_i,
  input  logic                              sys_rst_n_i,
  input  logic [NUM_SRC-1:0]                src_i,
  input  logic [NUM_SRC-1:0]                src_en_i,
  input  logic [NUM_SRC*PRESCALE_WIDTH-1:0] src_prescale_i,
  input  logic                              en_i,
  input  logic [NUM_SRC-1:0]                ext_src_en_i,
  input  logic [EXT_LEN_WIDTH-1:0]          ext_len_i,
  input  logic [HOLDOFF_WIDTH-1:0]          holdoff_i,
  input  logic                              soft_flow_ctrl_i,
  input  logic                              soft_flow_clr_i,
  input  logic                              readout_running_i,
  input  logic                              readout_done_i,
  input  logic                              readout_full_i,
  output logic                              trig_o,
  output logic [NUM_SRC-1:0]                trig_mask_o,
  output logic [EVCNT_WIDTH-1:0]            evnum_o,
  output logic                              ext_trig_o,
  output logic                              dead_trig_o,
  output logic                              trig_done_o,
  output logic                              busy_o,
  output logic                              soft_flow_waiting_o,
  output logic [31:0]                       dead_cycles_o,
  output logic [2:0]                        state_o
);

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_IDLE     = 3'd1,
    ST_TRIG     = 3'd2,
    ST_BUSY     = 3'd3,
    ST_HOLD     = 3'd4,
    ST_HOLDOFF  = 3'd5
  } state_t;

  // Asserted level of the external one-shot, reduced to a single bit.
  localparam logic EXT_ON = (EXT_LOGIC_TRUE != 0);

  state_t                    state;
  logic                      arm_r;
  logic [NUM_SRC-1:0]        q;
  logic [NUM_SRC-1:0]        q_r;
  logic [NUM_SRC-1:0]        passed;
  logic [PRESCALE_WIDTH-1:0] pcnt [NUM_SRC];
  logic [HOLDOFF_WIDTH-1:0]  hold_cnt;
  logic [EVCNT_WIDTH-1:0]    ev_cnt;
  logic [EXT_LEN_WIDTH-1:0]  ext_cnt;
  logic                      ext_active;
  logic                      done_pend;
  logic                      soft_seen;
  logic                      gate_open;
  logic                      locked;

  // Qualified hits: the source is enabled and its flag is high this cycle.
  assign q = src_i & src_en_i;

  // The lock covers every state between accepting a trigger and returning
  // to IDLE.
  assign locked = (state == ST_TRIG) || (state == ST_BUSY) ||
                  (state == ST_HOLD) || (state == ST_HOLDOFF);

  // Soft flow gate. A release pulse in the same cycle as the HOLD check
  // also opens the gate, so the pulse is never missed.
  assign gate_open = !soft_flow_ctrl_i || soft_seen || soft_flow_clr_i;

  assign busy_o              = locked;
  assign soft_flow_waiting_o = (state == ST_HOLD) && !readout_full_i && !gate_open;
  assign ext_trig_o          = ext_active ? EXT_ON : ~EXT_ON;
  assign state_o             = state;

  // Registers the arm condition and the qualified hits. This register stage
  // places trig_o two cycles after the source pulse.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      arm_r <= 1'b0;
      q_r   <= '0;
    end else begin
      arm_r <= en_i & readout_running_i;
      q_r   <= q;
    end
  end

  // Marks a source as passed when its registered hit lands on the prescale
  // terminal count.
  always_comb begin
    passed = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      passed[i] = q_r[i] &&
                  (pcnt[i] == src_prescale_i[i*PRESCALE_WIDTH +: PRESCALE_WIDTH]);
    end
  end

  // Per-source prescale counters. They count only while armed in IDLE and
  // wrap to 0 on the hit that passes.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        pcnt[i] <= '0;
      end
    end else if ((state == ST_IDLE) && arm_r) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (q_r[i]) begin
          if (passed[i]) begin
            pcnt[i] <= '0;
          end else begin
            pcnt[i] <= pcnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Main governor FSM. It also drives the registered trigger, done and dead
  // pulses, the event numbering and the external one-shot.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      state       <= ST_DISABLED;
      trig_o      <= 1'b0;
      trig_mask_o <= '0;
      evnum_o     <= '0;
      ev_cnt      <= '0;
      dead_trig_o <= 1'b0;
      trig_done_o <= 1'b0;
      hold_cnt    <= '0;
      ext_cnt     <= '0;
      ext_active  <= 1'b0;
      done_pend   <= 1'b0;
      soft_seen   <= 1'b0;
    end else begin
      trig_o      <= 1'b0;
      trig_done_o <= 1'b0;
      dead_trig_o <= (|q) && locked;

      // The one-shot runs out independently of the FSM. A new trigger or a
      // disarm below overrides this.
      if (ext_active) begin
        if (ext_cnt == '0) begin
          ext_active <= 1'b0;
        end else begin
          ext_cnt <= ext_cnt - 1'b1;
        end
      end

      // Remember a soft flow release seen at any point after the trigger.
      if (soft_flow_clr_i &&
          ((state == ST_TRIG) || (state == ST_BUSY) || (state == ST_HOLD))) begin
        soft_seen <= 1'b1;
      end

      if (!arm_r) begin
        // Disarm wins in every state. A readout still in flight is closed
        // with a single done pulse so the readout side sees the lock released.
        state      <= ST_DISABLED;
        ext_active <= 1'b0;
        done_pend  <= 1'b0;
        if ((state == ST_BUSY) || (state == ST_HOLD)) begin
          trig_done_o <= 1'b1;
        end
      end else begin
        case (state)
          ST_DISABLED: begin
            state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (|passed) begin
              state       <= ST_TRIG;
              trig_o      <= 1'b1;
              trig_mask_o <= passed;
              evnum_o     <= ev_cnt;
              ev_cnt      <= ev_cnt + 1'b1;
              done_pend   <= 1'b0;
              soft_seen   <= 1'b0;
              if (|(passed & ext_src_en_i)) begin
                ext_active <= 1'b1;
                ext_cnt    <= ext_len_i;
              end
            end
          end
          ST_TRIG: begin
            state <= ST_BUSY;
            // A fast readout can finish in the trigger cycle. Keep that pulse
            // for BUSY.
            if (readout_done_i) begin
              done_pend <= 1'b1;
            end
          end
          ST_BUSY: begin
            if (readout_done_i || done_pend) begin
              state     <= ST_HOLD;
              done_pend <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (!readout_full_i && gate_open) begin
              trig_done_o <= 1'b1;
              hold_cnt    <= holdoff_i;
              if (holdoff_i != '0) begin
                state <= ST_HOLDOFF;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_HOLDOFF: begin
            // Stay in HOLDOFF for hold_cnt cycles, from the loaded value
            // down to 1.
            if (hold_cnt <= 1) begin
              state <= ST_IDLE;
            end
            if (hold_cnt != '0) begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          default: begin
            state <= ST_DISABLED;
          end
        endcase
      end
    end
  end

`ifdef RADIANT_TRIG_DEADCNT_EN
  logic [31:0] dead_cnt;

  // Counts armed cycles spent outside IDLE. It saturates, and it clears when
  // the governor rearms from DISABLED.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      dead_cnt <= '0;
    end else if ((state == ST_DISABLED) && arm_r) begin
      dead_cnt <= '0;
    end else if (arm_r && (state != ST_IDLE) && (dead_cnt != 32'hFFFF_FFFF)) begin
      dead_cnt <= dead_cnt + 32'd1;
    end
  end

  assign dead_cycles_o = dead_cnt;
`else
  assign dead_cycles_o = '0;
`endif

endmodule

// File: tb/tb_radiant_trigger_governor.sv
// tb_radiant_trigger_governor
//   Directed sequence covering: reset, latency, prescale, dead hits, full
//   stall, holdoff, soft flow, the external one-shot, disarm and reset in
//   HOLD. A scoreboard queue holds {trig_mask, evnum} for every trigger the
//   stimulus expects. Each entry is popped when trig_o fires.
module tb_radiant_trigger_governor;
  localparam int NUM_SRC = 4;
  localparam int PW      = 8;
  localparam int HW      = 8;
  localparam int EW      = 32;
  localparam int XW      = 5;
  localparam int SBW     = NUM_SRC + EW;

  localparam logic [2:0] ST_DIS     = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_BUSY    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_HOLDOFF = 3'd5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_SRC-1:0] src, src_en, ext_src_en;
  logic [NUM_SRC*PW-1:0] prescale;
  logic               en, soft_ctrl, soft_clr, running, done, full;
  logic [XW-1:0]      ext_len;
  logic [HW-1:0]      holdoff;
  logic               trig_o, ext_trig_o, dead_trig_o, trig_done_o, busy_o, sfw_o;
  logic [NUM_SRC-1:0] trig_mask_o;
  logic [EW-1:0]      evnum_o;
  logic [31:0]        dead_cycles_o;
  logic [2:0]         state_o;

  logic [SBW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int trig_seen = 0, done_seen = 0, dead_seen = 0, ext_seen = 0;
  int ev_model = 0;

  radiant_trigger_governor dut (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .src_i(src), .src_en_i(src_en),
    .src_prescale_i(prescale), .en_i(en), .ext_src_en_i(ext_src_en),
    .ext_len_i(ext_len), .holdoff_i(holdoff), .soft_flow_ctrl_i(soft_ctrl),
    .soft_flow_clr_i(soft_clr), .readout_running_i(running),
    .readout_done_i(done), .readout_full_i(full), .trig_o(trig_o),
    .trig_mask_o(trig_mask_o), .evnum_o(evnum_o), .ext_trig_o(ext_trig_o),
    .dead_trig_o(dead_trig_o), .trig_done_o(trig_done_o), .busy_o(busy_o),
    .soft_flow_waiting_o(sfw_o), .dead_cycles_o(dead_cycles_o), .state_o(state_o)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [NUM_SRC-1:0] mask);
    exp_q.push_back({mask, ev_model[EW-1:0]});
    ev_model++;
  endtask

  task automatic pulse_src(input logic [NUM_SRC-1:0] m);
    src = m;
    tick();
    src = '0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n = 0;
    while (state_o !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, state_o, target);
  endtask

  // Scoreboard and pulse monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (trig_o === 1'b1) begin
        trig_seen++;
        n_checks++;
        assert (exp_q.size() != 0) n_pass++;
        else $error("FAIL sb_unexpected_trig observed=trig expected=none evnum=%0d", evnum_o);
        if (exp_q.size() != 0) check("sb_mask_evnum", {trig_mask_o, evnum_o}, exp_q.pop_front());
      end
      if (trig_done_o === 1'b1) done_seen++;
      if (dead_trig_o === 1'b1) dead_seen++;
      if (ext_trig_o === 1'b0) ext_seen++;
    end
  end

  initial begin
    int d0, t0, x0, pc;
    rst_n = 1'b0; src = '0; src_en = '0; prescale = '0; en = 1'b0;
    ext_src_en = '0; ext_len = '0; holdoff = '0; soft_ctrl = 1'b0;
    soft_clr = 1'b0; running = 1'b0; done = 1'b0; full = 1'b0;
    repeat (4) tick();

    // Reset values
    check("rst_state", state_o, ST_DIS);
    check("rst_trig", trig_o, 1'b0);
    check("rst_mask", trig_mask_o, '0);
    check("rst_evnum", evnum_o, '0);
    check("rst_ext", ext_trig_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", trig_done_o, 1'b0);
    check("rst_deadcyc", dead_cycles_o, '0);

    // Test 1: arm, single source 0 hit, two-cycle latency
    rst_n = 1'b1; en = 1'b1; running = 1'b1; src_en = 4'hF;
    wait_state(ST_IDLE, 10, "t1_arm_idle");
    d0 = done_seen;
    push_exp(4'b0001);
    pulse_src(4'b0001);
    check("t1_no_trig_1cyc", trig_o, 1'b0);
    tick();
    check("t1_trig_2cyc", trig_o, 1'b1);
    check("t1_mask", trig_mask_o, 4'b0001);
    check("t1_evnum", evnum_o, 32'd0);
    pulse_done();
    wait_state(ST_IDLE, 10, "t1_back_idle");
    tick();
    check("t1_done_count", done_seen - d0, 1);

    // Test 2: prescale 3 on source 1, eight spaced hits
    prescale[1*PW +: PW] = 8'd3;
    t0 = trig_seen;
    pc = 0;
    for (int k = 1; k <= 8; k++) begin
      if (pc == 3) begin
        pc = 0;
        push_exp(4'b0010);
      end else begin
        pc++;
      end
      pulse_src(4'b0010);
      tick(); tick();
      if (state_o == ST_BUSY) pulse_done();
      wait_state(ST_IDLE, 10, "t2_idle");
    end
    tick();
    check("t2_trig_count", trig_seen - t0, 2);
    prescale = '0;

    // Test 3: hit while BUSY is dead; done with full, then release
    push_exp(4'b0001);
    pulse_src(4'b0001);
    tick(); tick();
    check("t3_busy_state", state_o, ST_BUSY);
    check("t3_busy_o", busy_o, 1'b1);
    d0 = dead_seen; t0 = trig_seen;
    pulse_src(4'b0100);
    tick(); tick();
    check("t3_dead_count", dead_seen - d0, 1);
    check("t3_no_extra_trig", trig_seen - t0, 0);
    d0 = done_seen;
    full = 1'b1;
    pulse_done();
    tick();
    check("t3_hold_full", state_o, ST_HOLD);
    full = 1'b0;
    tick(); tick();
    check("t3_done_once", done_seen - d0, 1);
    check("t3_idle", state_o, ST_IDLE);

    // Test 4: full held 10 cycles in HOLD, then holdoff of 5
    holdoff = 8'd5;
    push_exp(4'b0001);
    pulse_src(4'b0001);
    tick(); tick();
    full = 1'b1;
    pulse_done();
    repeat (10) tick();
    check("t4_stay_hold", state_o, ST_HOLD);
    full = 1'b0;
    tick();
    check("t4_trig_done", trig_done_o, 1'b1);
    check("t4_holdoff", state_o, ST_HOLDOFF);
    repeat (4) tick();
    check("t4_holdoff_still", state_o, ST_HOLDOFF);
    tick();
    check("t4_idle_after_5", state_o, ST_IDLE);
    holdoff = '0;

    // Test 5: soft flow gate, done in the TRIG cycle, ext one-shot of 4 cycles
    soft_ctrl = 1'b1; ext_src_en = 4'b0001; ext_len = 5'd3;
    x0 = ext_seen; d0 = done_seen;
    push_exp(4'b0001);
    pulse_src(4'b0001);
    tick();
    check("t5_trig", trig_o, 1'b1);
    check("t5_ext_on", ext_trig_o, 1'b0);
    pulse_done();
    tick();
    check("t5_hold", state_o, ST_HOLD);
    check("t5_sfw", sfw_o, 1'b1);
    tick();
    check("t5_sfw_hold", state_o, ST_HOLD);
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    check("t5_trig_done", trig_done_o, 1'b1);
    check("t5_sfw_off", sfw_o, 1'b0);
    repeat (3) tick();
    check("t5_ext_len", ext_seen - x0, 4);
    check("t5_done_once", done_seen - d0, 1);
    soft_ctrl = 1'b0;

    // Test 6: disarm in BUSY, then reset while in HOLD
    x0 = ext_seen; d0 = done_seen;
    push_exp(4'b0001);
    pulse_src(4'b0001);
    tick(); tick();
    en = 1'b0;
    tick(); tick();
    check("t6_disabled", state_o, ST_DIS);
    check("t6_done_pulse", trig_done_o, 1'b1);
    check("t6_ext_idle", ext_trig_o, 1'b1);
    repeat (3) tick();
    check("t6_done_once", done_seen - d0, 1);
    check("t6_ext_cut", ext_seen - x0, 3);
    en = 1'b1;
    wait_state(ST_IDLE, 10, "t6_rearm");
    push_exp(4'b0001);
    pulse_src(4'b0001);
    tick(); tick();
    full = 1'b1;
    pulse_done();
    check("t6_in_hold", state_o, ST_HOLD);
    rst_n = 1'b0;
    tick();
    check("t6_rst_state", state_o, ST_DIS);
    check("t6_rst_mask", trig_mask_o, '0);
    check("t6_rst_evnum", evnum_o, '0);
    check("t6_rst_ext", ext_trig_o, 1'b1);
    check("t6_rst_busy", busy_o, 1'b0);
    check("t6_rst_done", trig_done_o, 1'b0);
    rst_n = 1'b1; full = 1'b0;
    repeat (2) tick();
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
